// File: rtl/uart_param_core_if.sv
// Host-side handshake bundle of uart_param_core: transmit request/status and
// receive data/status. The serial lines stay plain ports so cores can be cross-wired.
interface uart_param_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic [DATA_BITS-1:0] tx_input;
  logic                 tx_busy;
  logic                 tx_done;
  logic [DATA_BITS-1:0] rx_output;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output start, tx_input,
    input  tx_busy, tx_done, rx_output, rx_done, parity_err, frame_err
  );

  modport slave (
    input  start, tx_input,
    output tx_busy, tx_done, rx_output, rx_done, parity_err, frame_err
  );
endinterface

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: start/data/parity/stop framing on TX, and a
// mid-bit sampling RX with parity, framing-error and false-start handling.
module uart_param_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_param_core_if.slave  bus,
  output logic              tx,
  input  logic              rx
);

  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam bit HAS_PARITY = (PARITY != 0);
  localparam bit ODD        = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

  // ---------------------------------------------------------------- transmitter
  state_t               tx_state, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                 tx_par, tx_par_d;
  logic                 tx_q, tx_d, tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_idx    <= tx_idx_d;
      tx_shift  <= tx_shift_d;
      tx_par    <= tx_par_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 1'b1;
    tx_idx_d   = tx_idx;
    tx_shift_d = tx_shift;
    tx_par_d   = tx_par;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (bus.start) begin
          tx_state_d = S_START;
          tx_shift_d = bus.tx_input;
          tx_par_d   = (^bus.tx_input) ^ ODD;
        end
      end
      S_START:
        if (tx_cnt == BIT_LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
        end
      S_DATA:
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx == IDX_LAST) begin
            tx_state_d = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            tx_idx_d   = tx_idx + 1'b1;
            tx_shift_d = tx_shift >> 1;
          end
        end
      S_PARITY:
        if (tx_cnt == BIT_LAST) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = '0;
        end
      S_STOP:
        if (tx_cnt == STOP_LAST) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
        end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so tx/tx_busy change on the accepting edge.
  always_comb begin
    tx_busy_d = (tx_state_d != S_IDLE);
    tx_done_d = (tx_state == S_STOP) && (tx_state_d == S_IDLE);
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_shift_d[0];
      S_PARITY: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx          = tx_q;
  assign bus.tx_busy = tx_busy_q;
  assign bus.tx_done = tx_done_q;

  // ------------------------------------------------------------------- receiver
  state_t               rx_state, rx_state_d;
  logic                 rx_meta, rx_sync;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic                 rx_par, rx_par_d;
  logic                 stop_take, perr_calc, stop_hit_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 perr_q, ferr_q, rx_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_hit_q <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_idx     <= rx_idx_d;
      rx_shift   <= rx_shift_d;
      rx_par     <= rx_par_d;
      stop_hit_q <= stop_take;
      rx_done_q  <= stop_hit_q;
      if (stop_take) begin
        rx_data_q <= rx_shift;
        perr_q    <= perr_calc;
        ferr_q    <= ~rx_sync;
      end
    end
  end

  // IDLE is only ever entered with the synchronised line high, so a low level
  // seen there is the 1->0 start transition.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 1'b1;
    rx_idx_d   = rx_idx;
    rx_shift_d = rx_shift;
    rx_par_d   = rx_par;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync) rx_state_d = S_START;
      end
      S_START:
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_idx == IDX_LAST) rx_state_d = HAS_PARITY ? S_PARITY : S_STOP;
          else                    rx_idx_d   = rx_idx + 1'b1;
        end
      S_PARITY:
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync;
          rx_state_d = S_STOP;
        end
      S_STOP:
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync ? S_IDLE : S_WAIT;
        end
      S_WAIT: begin
        rx_cnt_d = '0;
        if (rx_sync) rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stop_take = (rx_state == S_STOP) && (rx_cnt == BIT_LAST);
    perr_calc = HAS_PARITY && (((^rx_shift) ^ ODD) != rx_par);
  end

  assign bus.rx_output  = rx_data_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_param_core.sv
// Loopback bench: pair a->b (16, 8, none, 1) and pair c->d (16, 7, even, 2),
// with bench-controlled line override on b and parity-bit corruption on d.
module tb_uart_param_core;
  localparam int C = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_param_core_if #(.DATA_BITS(8)) bus_a ();
  uart_param_core_if #(.DATA_BITS(8)) bus_b ();
  uart_param_core_if #(.DATA_BITS(7)) bus_c ();
  uart_param_core_if #(.DATA_BITS(7)) bus_d ();

  logic tx_a, tx_b, tx_c, tx_d;
  logic mode_b = 1'b0, drive_b = 1'b1, flip = 1'b0;
  logic rx_b_line, rx_d_line;
  assign rx_b_line = mode_b ? drive_b : tx_a;
  assign rx_d_line = tx_c ^ flip;

  uart_param_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .tx(tx_a), .rx(tx_b));
  uart_param_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .tx(tx_b), .rx(rx_b_line));
  uart_param_core #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .tx(tx_c), .rx(tx_d));
  uart_param_core #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d (
    .clk(clk), .rst_n(rst_n), .bus(bus_d), .tx(tx_d), .rx(rx_d_line));

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } rx_ev_t;

  rx_ev_t rxq_b[$], rxq_d[$];
  int     txq_a[$], txq_c[$];

  function automatic rx_ev_t mk_ev(input logic [8:0] d, input logic p, input logic f, input int c);
    rx_ev_t e;
    e.data = d; e.perr = p; e.ferr = f; e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus_a.tx_done) txq_a.push_back(cyc);
    if (bus_c.tx_done) txq_c.push_back(cyc);
    if (bus_b.rx_done) rxq_b.push_back(mk_ev(9'(bus_b.rx_output), bus_b.parity_err, bus_b.frame_err, cyc));
    if (bus_d.rx_done) rxq_d.push_back(mk_ev(9'(bus_d.rx_output), bus_d.parity_err, bus_d.frame_err, cyc));
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference frame: start, payload LSB first, optional parity, stop bits.
  function automatic void build_frame(input logic [8:0] d, input int db, input int pm,
                                      input int sb, output logic [15:0] bits, output int n);
    int ones;
    ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < db; i++) begin
      bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (pm != 0) begin
      bits[n] = (pm == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      n++;
    end
    n += sb;
  endfunction

  // Start edge, two synchroniser stages and the IDLE sampling edge, half a bit,
  // then one bit per data/parity/stop centre, then rx_done one cycle later.
  function automatic int rx_lat(input int db, input int pm);
    return 3 + C / 2 + (db + ((pm != 0) ? 1 : 0) + 1) * C + 1;
  endfunction

  function automatic logic line_of(input int sel);
    return (sel != 0) ? tx_c : tx_a;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? bus_c.tx_busy : bus_a.tx_busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel != 0) ? bus_c.tx_done : bus_a.tx_done;
  endfunction

  // One frame on pair sel (0: a->b, 1: c->d), checking the wire bit by bit,
  // tx_done timing and the received result.
  task automatic send_frame(input int sel, input logic [8:0] d, input bit disturb, input bit flip_par);
    logic [15:0] bits;
    int n, db, pm, sb, k, tx_n0, rx_n0;
    rx_ev_t ev;
    db = (sel != 0) ? 7 : 8;
    pm = sel;
    sb = (sel != 0) ? 2 : 1;
    build_frame(d, db, pm, sb, bits, n);
    tx_n0 = (sel != 0) ? txq_c.size() : txq_a.size();
    rx_n0 = (sel != 0) ? rxq_d.size() : rxq_b.size();
    if (sel != 0) begin bus_c.tx_input = d[6:0]; bus_c.start = 1'b1; end
    else          begin bus_a.tx_input = d[7:0]; bus_a.start = 1'b1; end
    step();
    k = cyc;
    bus_a.start = 1'b0;
    bus_c.start = 1'b0;
    check("tx_start_low", line_of(sel), 0);
    check("tx_busy_set", busy_of(sel), 1);
    for (int t = 1; t <= n * C + 2; t++) begin
      step();
      if (flip_par) flip = (t >= (1 + db) * C) && (t < (2 + db) * C);
      if (disturb && t == 3 * C) begin
        bus_a.start = 1'b1; bus_a.tx_input = ~d[7:0];
        bus_c.start = 1'b1; bus_c.tx_input = ~d[6:0];
      end
      if (disturb && t == 3 * C + 1) begin
        bus_a.start = 1'b0;
        bus_c.start = 1'b0;
      end
      if (t % C == C / 2) check($sformatf("tx_bit%0d", t / C), line_of(sel), bits[t / C]);
      if (t == n * C) begin
        check("tx_done_pulse", done_of(sel), 1);
        check("tx_busy_clear", busy_of(sel), 0);
        check("tx_idle_high", line_of(sel), 1);
      end
    end
    flip = 1'b0;
    if (sel != 0) begin
      check("tx_done_count", txq_c.size(), tx_n0 + 1);
      if (txq_c.size() > tx_n0) check("tx_done_cycle", txq_c[tx_n0] - k, n * C);
      check("rx_done_count", rxq_d.size(), rx_n0 + 1);
      if (rxq_d.size() > rx_n0) ev = rxq_d[rx_n0];
    end else begin
      check("tx_done_count", txq_a.size(), tx_n0 + 1);
      if (txq_a.size() > tx_n0) check("tx_done_cycle", txq_a[tx_n0] - k, n * C);
      check("rx_done_count", rxq_b.size(), rx_n0 + 1);
      if (rxq_b.size() > rx_n0) ev = rxq_b[rx_n0];
    end
    if (((sel != 0) ? rxq_d.size() : rxq_b.size()) > rx_n0) begin
      check("rx_data", ev.data, d);
      check("rx_parity_err", ev.perr, flip_par);
      check("rx_frame_err", ev.ferr, 0);
      check("rx_done_cycle", ev.cyc - k, rx_lat(db, pm));
    end
  endtask

  // Bench-driven 8N1 frame on b's line with a selectable stop level.
  task automatic drive_serial(input logic [7:0] d, input logic stop_val);
    drive_b = 1'b0;
    repeat (C) step();
    for (int i = 0; i < 8; i++) begin
      drive_b = d[i];
      repeat (C) step();
    end
    drive_b = stop_val;
    repeat (C) step();
  endtask

  initial begin
    int n0, k, nt, nr, tf;
    logic [6:0] v [3];
    bus_a.start = 1'b0; bus_a.tx_input = '0;
    bus_b.start = 1'b0; bus_b.tx_input = '0;
    bus_c.start = 1'b0; bus_c.tx_input = '0;
    bus_d.start = 1'b0; bus_d.tx_input = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_tx", tx_a, 1);
    check("rst_tx_busy", bus_a.tx_busy, 0);
    check("rst_tx_done", bus_a.tx_done, 0);
    check("rst_rx_output", bus_b.rx_output, 0);
    check("rst_rx_done", bus_b.rx_done, 0);
    check("rst_parity_err", bus_b.parity_err, 0);
    check("rst_frame_err", bus_b.frame_err, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Default loopback, then random payloads with a mid-frame start pulse and tx_input churn.
    send_frame(0, 9'h0A5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(0, 9'($urandom_range(0, 255)), 1'b1, 1'b0);

    // False start: 3-cycle glitch, then a real frame.
    mode_b = 1'b1; drive_b = 1'b1;
    repeat (4) step();
    n0 = rxq_b.size();
    drive_b = 1'b0;
    repeat (3) step();
    drive_b = 1'b1;
    repeat (20 * C) step();
    check("false_start_no_done", rxq_b.size(), n0);
    mode_b = 1'b0;
    send_frame(0, 9'h03C, 1'b0, 1'b0);

    // Framing error followed by a break, then recovery.
    mode_b = 1'b1; drive_b = 1'b1;
    repeat (C) step();
    n0 = rxq_b.size();
    drive_serial(8'h81, 1'b0);
    repeat (3 * C) step();
    check("ferr_done_count", rxq_b.size(), n0 + 1);
    if (rxq_b.size() > n0) begin
      check("ferr_data", rxq_b[n0].data, 9'h081);
      check("ferr_flag", rxq_b[n0].ferr, 1);
      check("ferr_perr", rxq_b[n0].perr, 0);
    end
    check("ferr_held", bus_b.frame_err, 1);
    drive_b = 1'b1;
    repeat (C) step();
    check("break_no_redone", rxq_b.size(), n0 + 1);
    drive_serial(8'h42, 1'b1);
    drive_b = 1'b1;
    repeat (C) step();
    check("recover_count", rxq_b.size(), n0 + 2);
    if (rxq_b.size() > n0 + 1) begin
      check("recover_data", rxq_b[n0 + 1].data, 9'h042);
      check("recover_ferr", rxq_b[n0 + 1].ferr, 0);
    end
    mode_b = 1'b0;

    // Even parity, 7 data bits, 2 stop bits: clean, corrupted, then random.
    send_frame(1, 9'h05A, 1'b0, 1'b0);
    send_frame(1, 9'h05A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(1, 9'($urandom_range(0, 127)), 1'b0, 1'b0);

    // start held high for three contiguous frames; tx_input changes mid-frame.
    for (int i = 0; i < 3; i++) v[i] = 7'($urandom_range(0, 127));
    tf = 11 * C;
    nt = txq_c.size();
    nr = rxq_d.size();
    bus_c.tx_input = v[0];
    bus_c.start = 1'b1;
    step();
    k = cyc;
    check("held_first_start", tx_c, 0);
    for (int t = 1; t <= 3 * tf + 10; t++) begin
      step();
      if (t == tf / 2)              bus_c.tx_input = v[1];
      if (t == tf + 1 + tf / 2)     bus_c.tx_input = v[2];
      if (t == 2 * tf + 2 + tf / 2) bus_c.start = 1'b0;
      if (t == tf || t == 2 * tf + 1) check("held_gap_high", tx_c, 1);
      if (t == tf + 1 || t == 2 * tf + 2) check("held_restart", tx_c, 0);
    end
    check("held_idle_after", bus_c.tx_busy, 0);
    check("held_tx_count", txq_c.size(), nt + 3);
    check("held_rx_count", rxq_d.size(), nr + 3);
    for (int i = 0; i < 3; i++) begin
      if (txq_c.size() > nt + i) check("held_done_cycle", txq_c[nt + i] - k, (i + 1) * tf + i);
      if (rxq_d.size() > nr + i) begin
        check("held_rx_data", rxq_d[nr + i].data, 9'(v[i]));
        check("held_rx_perr", rxq_d[nr + i].perr, 0);
      end
    end

    // One-cycle reset in the middle of the data bits.
    n0 = rxq_b.size();
    bus_a.tx_input = 8'h55;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (3 * C) step();
    rst_n = 1'b0;
    step();
    check("midrst_tx", tx_a, 1);
    check("midrst_tx_busy", bus_a.tx_busy, 0);
    check("midrst_tx_done", bus_a.tx_done, 0);
    check("midrst_rx_output", bus_b.rx_output, 0);
    check("midrst_rx_done", bus_b.rx_done, 0);
    check("midrst_parity_err", bus_b.parity_err, 0);
    check("midrst_frame_err", bus_b.frame_err, 0);
    check("midrst_rx_output_d", bus_d.rx_output, 0);
    rst_n = 1'b1;
    repeat (4) step();
    check("midrst_no_done", rxq_b.size(), n0);
    send_frame(0, 9'h0FF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
